// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM state encoding and the canonical NOP word.
`timescale 1ns/1ps
package cpu_defs;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, single-outstanding imem request/response handshake,
// and the IF/ID output slot. Redirects reload the PC and discard stale fetches.
`timescale 1ns/1ps
module instruction_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, req_pc;
  logic         out_of_reset;
  logic         slot_free, accept, load_slot;

  // Issuing only into a free slot guarantees the slot is empty when data returns.
  assign slot_free = !if_valid || id_ready;
  assign imem_req  = out_of_reset && (state == ST_ISSUE) && slot_free;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign load_slot = (state == ST_WAIT) && imem_rvalid && !redirect_valid;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_ISSUE: begin
        if (accept) state_next = redirect_valid ? ST_DISCARD : ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid)         state_next = ST_ISSUE;
        else if (redirect_valid) state_next = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_next = ST_ISSUE;
      end
      default: state_next = ST_ISSUE;
    endcase
    // A redirect wins over pc+4 even when a request is accepted in the same cycle.
    if (redirect_valid)  pc_next = {redirect_pc[31:2], 2'b00};
    else if (accept)     pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_n) begin
      state        <= ST_ISSUE;
      pc           <= RESET_PC;
      req_pc       <= '0;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      out_of_reset <= 1'b1;
      if (accept) req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid       <= 1'b0;
      if_instruction <= INSTR_NOP;
      if_pc          <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (load_slot) begin
      if_valid       <= 1'b1;
      if_instruction <= imem_rdata;
      if_pc          <= req_pc;
    end else if (if_valid && id_ready) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed sequences, a redirect
// vector table, and a randomized-latency run checked against a PC scoreboard.
`timescale 1ns/1ps
module tb_instruction_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        id_ready;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hC0DE_0003;
  endfunction

  // Memory responder: one outstanding request, configurable or random latencies.
  int          rsp_lat   = 1;
  int          ready_lat = 0;
  bit          rand_mode = 1'b0;
  bit          pending   = 1'b0;
  logic [31:0] pend_addr = '0;
  int          rsp_cnt   = 0;
  int          wait_cnt  = 0;

  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pending  = 1'b0;
        wait_cnt = 0;
      end else begin
        if (imem_rvalid) pending = 1'b0;
        if (imem_req && imem_ready) begin
          pending   = 1'b1;
          pend_addr = imem_addr;
          rsp_cnt   = rand_mode ? int'($urandom_range(1, 8)) : rsp_lat;
          wait_cnt  = rand_mode ? int'($urandom_range(0, 7)) : ready_lat;
        end else if (imem_req && !imem_ready && wait_cnt > 0) begin
          wait_cnt--;
        end
      end
      #1;
      imem_rvalid = 1'b0;
      if (pending) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end
      end
      imem_ready = !pending && (wait_cnt == 0);
    end
  end

  // Scoreboard for the random phase: consumed PCs must step by 4 between redirects.
  bit          sb_en   = 1'b0;
  logic [31:0] sb_pc   = '0;
  int          fetched = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (sb_en && rst_n) begin
        if (redirect_valid) begin
          sb_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (if_valid && id_ready) begin
          check("rand_pc", if_pc, sb_pc);
          check("rand_instr", if_instruction, mem_word(sb_pc));
          sb_pc = sb_pc + 32'd4;
          fetched++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input string name);
    int n = 0;
    @(negedge clk);
    while (!if_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_slot_valid"}, if_valid, 1'b1);
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } redir_vec_t;

  redir_vec_t vecs [4];
  int         cyc;

  initial begin
    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
    vecs[3] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};

    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) step();

    // Reset values
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", if_valid, 1'b0);
    check("rst_instr", if_instruction, INSTR_NOP);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h100);

    // First fetch: request appears one cycle after the first edge out of reset
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req_early", imem_req, 1'b0);
    @(negedge clk);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h100);
    wait_slot("first");
    check("first_instr", if_instruction, 32'h0050_0093);
    check("first_if_pc", if_pc, 32'h100);
    check("first_next_addr", imem_addr, 32'h104);

    // Stall: slot held, no requests
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", imem_req, 1'b0);
      check("stall_if_pc", if_pc, 32'h100);
      check("stall_instr", if_instruction, 32'h0050_0093);
    end

    // Release, then redirect while the 0x104 fetch is outstanding
    step();
    id_ready = 1'b1; rsp_lat = 3;
    @(negedge clk);
    check("release_req", imem_req, 1'b1);
    check("release_addr", imem_addr, 32'h104);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check("wait_req", imem_req, 1'b0);
    check("wait_valid", if_valid, 1'b0);
    step();
    redirect_valid = 1'b0; rsp_lat = 1;
    @(negedge clk);
    check("rw_addr", imem_addr, 32'h200);
    check("rw_valid", if_valid, 1'b0);
    check("rw_discard_req", imem_req, 1'b0);
    step();
    @(negedge clk);
    check("rw_rvalid_cycle_req", imem_req, 1'b0);
    step();
    @(negedge clk);
    check("rw_dropped_valid", if_valid, 1'b0);
    check("rw_reissue_req", imem_req, 1'b1);
    check("rw_reissue_addr", imem_addr, 32'h200);
    wait_slot("rw");
    check("rw_if_pc", if_pc, 32'h200);
    check("rw_instr", if_instruction, mem_word(32'h200));
    check("rw_next_addr", imem_addr, 32'h204);

    // Redirect coincident with acceptance of 0x204
    redirect_valid = 1'b1; redirect_pc = 32'h200; rsp_lat = 2;
    check("ra_req_pre", imem_req, 1'b1);
    step();
    redirect_valid = 1'b0; rsp_lat = 1;
    @(negedge clk);
    check("ra_addr", imem_addr, 32'h200);
    check("ra_valid", if_valid, 1'b0);
    check("ra_req", imem_req, 1'b0);
    wait_slot("ra");
    check("ra_if_pc", if_pc, 32'h200);
    check("ra_instr", if_instruction, mem_word(32'h200));

    // Redirect coincident with rvalid
    check("rr_req_pre", imem_req, 1'b1);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rr_valid", if_valid, 1'b0);
    check("rr_issue_req", imem_req, 1'b1);
    check("rr_addr", imem_addr, 32'h400);
    wait_slot("rr");
    check("rr_if_pc", if_pc, 32'h400);
    id_ready = 1'b0;

    // Redirect target table: alignment and wrap
    for (int v = 0; v < 4; v++) begin
      step();
      redirect_valid = 1'b1; redirect_pc = vecs[v].target;
      step();
      redirect_valid = 1'b0; id_ready = 1'b1;
      @(negedge clk);
      check("vec_addr", imem_addr, vecs[v].exp_addr);
      check("vec_flush", if_valid, 1'b0);
      wait_slot("vec");
      check("vec_if_pc", if_pc, vecs[v].exp_addr);
      check("vec_instr", if_instruction, mem_word(vecs[v].exp_addr));
      check("vec_next_addr", imem_addr, vecs[v].exp_next);
      id_ready = 1'b0;
    end

    // Random latency / random id_ready / occasional redirects
    rand_mode = 1'b1;
    step();
    sb_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    step();
    redirect_valid = 1'b0;
    cyc = 0;
    while (fetched < 1000 && cyc < 40000) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 63) == 0);
      redirect_pc    = $urandom;
      step();
      cyc++;
    end
    redirect_valid = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    sb_en = 1'b0;
    check("rand_fetch_count_reached", (fetched >= 1000), 1'b1);

    // Reset mid-operation
    rand_mode = 1'b0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", if_valid, 1'b0);
    check("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_instr", if_instruction, INSTR_NOP);
    check("mid_rst_addr", imem_addr, 32'h100);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V pipeline. Holds the program counter, fetches one 32-bit instruction word at a time from instruction memory over a request/response handshake, and presents it with its PC in an IF/ID output register. The decode stage reads this register, and `ImmediateGenerator` consumes `if_instruction`. Branch/jump redirects from execute reload the PC and discard any stale fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; always equals the PC register.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  branch taken or jump; single-cycle pulse.
- `redirect_pc`  in  32  target address; bits [1:0] are ignored and forced to 0.
- `if_valid`  out  1  IF/ID register holds a valid instruction.
- `if_instruction`  out  32  fetched word.
- `if_pc`  out  32  address of `if_instruction`.
- `id_ready`  in  1  decode consumes the slot this cycle when `if_valid`=1.

## Operation
- A request is accepted when `imem_req & imem_ready`. At most one request is outstanding. Responses return in order, at least 1 cycle after acceptance, with unbounded latency.
- The FSM state type goes in `cpu_defs` as `fetch_state_t`:
  - ST_ISSUE: `imem_req`=1 iff the slot is free (`!if_valid` or `if_valid & id_ready`). On acceptance, `pc<=pc+4` and go to ST_WAIT.
  - ST_WAIT: on `imem_rvalid`, load the slot (`if_valid<=1`, `if_instruction<=imem_rdata`, `if_pc<=` address of the request) and go to ST_ISSUE.
  - ST_DISCARD: on `imem_rvalid`, drop the data, leave the slot untouched, and go to ST_ISSUE.
- Issuing only when the slot is free guarantees the slot is empty when the response arrives. No skid buffer is needed.
- A request is uncommitted until accepted. `imem_addr` may change while `imem_req`=1 and `imem_ready`=0.
- Redirect (highest priority, any state):
  - `pc<={redirect_pc[31:2],2'b00}`.
  - `if_valid<=0`. This overrides `id_ready`; a consumed or held slot is flushed.
  - In ST_ISSUE with an acceptance in the same cycle: the accepted request is stale. Go to ST_DISCARD, and the PC still takes the redirect target, not pc+4.
  - In ST_WAIT with no `imem_rvalid`: go to ST_DISCARD.
  - In ST_WAIT with `imem_rvalid` in the same cycle: discard the data and go to ST_ISSUE.
  - In ST_DISCARD: stay in ST_DISCARD, unless `imem_rvalid` arrives that cycle, in which case go to ST_ISSUE.
  - In ST_ISSUE with no acceptance: stay in ST_ISSUE.
- Stall: `if_valid`=1 and `id_ready`=0 holds `if_instruction` and `if_pc` stable and keeps `imem_req`=0.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- The block keeps a request-address register `req_pc`, captured at acceptance, to source `if_pc`.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state = ST_ISSUE
  - `pc` = `RESET_PC`
  - `imem_req` = 0 (gated by a registered `out_of_reset` flag)
  - `if_valid` = 0
  - `if_instruction` = 32'h0000_0013 (NOP)
  - `if_pc` = 0
- First request: `imem_req`=1 on the first rising edge after `rst_n` deasserts, plus one cycle.
- Latency: acceptance at edge N and `imem_rvalid` in cycle N+k give `if_valid`=1 from the edge ending cycle N+k.
- Back-to-back throughput with zero-wait memory (`rvalid` the cycle after acceptance) and `id_ready`=1 is one instruction per 2 cycles.
- `redirect_valid` at edge N gives `imem_addr`=target in cycle N+1, and `if_valid`=0 in cycle N+1.
- Reset mid-operation aborts everything. Any response arriving after reset deassertion without a new acceptance is ignored, because the state is ST_ISSUE.

## Structure
- Add to package `cpu_defs`: `fetch_state_t` (ST_ISSUE, ST_WAIT, ST_DISCARD) and `INSTR_NOP` = 32'h0000_0013.
- Single module, no sub-modules. The IF/ID slot is inline.

## Test plan
- **Reset/first fetch:** deassert `rst_n` with `RESET_PC`=32'h100 and zero-wait memory returning 32'h00500093 → `imem_addr`=32'h100, then `if_valid`=1, `if_instruction`=32'h00500093, `if_pc`=32'h100, next `imem_addr`=32'h104.
- **Stall:** hold `id_ready`=0 for 5 cycles with a valid slot → `imem_req`=0 and outputs stable; release → next request at the following address.
- **Redirect in WAIT:** accept 32'h104, pulse redirect to 32'h200 before `rvalid`, response arrives 3 cycles later → data dropped, `if_valid` stays 0, next request at 32'h200, `if_pc`=32'h200.
- **Redirect coincident with acceptance:** stale response dropped; `imem_addr`=32'h200.
- **Redirect coincident with `rvalid`:** data dropped, ST_ISSUE next cycle.
- **Misaligned target and wrap:** redirect to 32'h203 → fetch at 32'h200. Redirect to 32'hFFFF_FFFC → following fetch at 32'h0.
- **Random memory latency** (0-7 wait cycles on both handshakes, random `id_ready`) over 1000 fetches → `if_pc` sequence strictly +4 between redirects, no duplicated or lost instructions.
